// File: rtl/hdmi_rd_arbiter_if.sv
// Bus between the two HDMI read requesters, the arbiter, and the downstream read engine.
// The master side drives requests and cmd_busy; the slave side is the arbiter.
interface hdmi_rd_arbiter_if #(
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned AW = 32;

    logic [1:0]       req_kick;
    logic [AW-1:0]    req_addr0;
    logic [AW-1:0]    req_addr1;
    logic [AW-1:0]    req_num0;
    logic [AW-1:0]    req_num1;
    logic [AW-1:0]    base_addr0;
    logic [AW-1:0]    base_addr1;
    logic [1:0]       req_ack;
    logic [1:0]       req_done;
    logic             cmd_kick;
    logic [AW-1:0]    cmd_addr;
    logic [AW-1:0]    cmd_num;
    logic             cmd_busy;
    logic [CNT_W-1:0] grant_cnt0;
    logic [CNT_W-1:0] grant_cnt1;

    modport slave (
        input  req_kick, req_addr0, req_addr1, req_num0, req_num1,
               base_addr0, base_addr1, cmd_busy,
        output req_ack, req_done, cmd_kick, cmd_addr, cmd_num,
               grant_cnt0, grant_cnt1
    );

    modport master (
        output req_kick, req_addr0, req_addr1, req_num0, req_num1,
               base_addr0, base_addr1, cmd_busy,
        input  req_ack, req_done, cmd_kick, cmd_addr, cmd_num,
               grant_cnt0, grant_cnt1
    );
endinterface

// File: rtl/hdmi_rd_arbiter.sv
// Two-port read arbiter: video prefetch (port 0) has priority, the auxiliary
// reader (port 1) is guaranteed a slot after STARVE_LIMIT consecutive port-0 grants.
module hdmi_rd_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic               clk_vga,
    input  logic               rst,
    hdmi_rd_arbiter_if.slave   bus
);
    localparam int unsigned AW   = 32;
    localparam int unsigned SC_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              cmd_kick_q, cmd_kick_d;
    logic [AW-1:0]     cmd_addr_q, cmd_addr_d;
    logic [AW-1:0]     cmd_num_q, cmd_num_d;
    logic [1:0]        req_ack_q, req_ack_d;
    logic [1:0]        req_done_q, req_done_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic [CNT_W-1:0]  gcnt0_q, gcnt0_d;
    logic [CNT_W-1:0]  gcnt1_q, gcnt1_d;

    logic              win_c;
    logic [AW-1:0]     win_addr_c;
    logic [AW-1:0]     win_num_c;
    logic [1:0]        win_oh_c;

    // Winner selection and its command payload; address wraps mod 2^32
    always_comb begin
        win_c      = bus.req_kick[1] && (!bus.req_kick[0] || (starve_q >= SC_W'(STARVE_LIMIT)));
        win_addr_c = win_c ? (bus.base_addr1 + bus.req_addr1) : (bus.base_addr0 + bus.req_addr0);
        win_num_c  = win_c ? bus.req_num1 : bus.req_num0;
        win_oh_c   = win_c ? 2'b10 : 2'b01;
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        cmd_kick_d = cmd_kick_q;
        cmd_addr_d = cmd_addr_q;
        cmd_num_d  = cmd_num_q;
        req_ack_d  = 2'b00;
        req_done_d = 2'b00;
        starve_d   = starve_q;
        gcnt0_d    = gcnt0_q;
        gcnt1_d    = gcnt1_q;

        case (state_q)
            S_IDLE: begin
                cmd_kick_d = 1'b0;
                if (!bus.cmd_busy && (bus.req_kick != 2'b00)) begin
                    grant_d    = win_c;
                    cmd_addr_d = win_addr_c;
                    cmd_num_d  = win_num_c;
                    if (win_c) begin
                        starve_d = '0;
                        if (gcnt1_q != '1) gcnt1_d = gcnt1_q + CNT_W'(1);
                    end else begin
                        if (!bus.req_kick[1])      starve_d = '0;
                        else if (starve_q != '1)   starve_d = starve_q + SC_W'(1);
                        if (gcnt0_q != '1) gcnt0_d = gcnt0_q + CNT_W'(1);
                    end
                    // Zero-length requests complete at the grant without touching the bus
                    if (win_num_c == '0) begin
                        req_ack_d  = win_oh_c;
                        req_done_d = win_oh_c;
                    end else begin
                        cmd_kick_d = 1'b1;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cmd_kick_d = 1'b1;
                if (bus.cmd_busy) begin
                    cmd_kick_d = 1'b0;
                    req_ack_d  = grant_q ? 2'b10 : 2'b01;
                    state_d    = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                cmd_kick_d = 1'b0;
                if (!bus.cmd_busy) begin
                    req_done_d = grant_q ? 2'b10 : 2'b01;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                cmd_kick_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= 1'b0;
            cmd_kick_q <= 1'b0;
            cmd_addr_q <= '0;
            cmd_num_q  <= '0;
            req_ack_q  <= 2'b00;
            req_done_q <= 2'b00;
            starve_q   <= '0;
            gcnt0_q    <= '0;
            gcnt1_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            cmd_kick_q <= cmd_kick_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_num_q  <= cmd_num_d;
            req_ack_q  <= req_ack_d;
            req_done_q <= req_done_d;
            starve_q   <= starve_d;
            gcnt0_q    <= gcnt0_d;
            gcnt1_q    <= gcnt1_d;
        end
    end

    assign bus.cmd_kick   = cmd_kick_q;
    assign bus.cmd_addr   = cmd_addr_q;
    assign bus.cmd_num    = cmd_num_q;
    assign bus.req_ack    = req_ack_q;
    assign bus.req_done   = req_done_q;
    assign bus.grant_cnt0 = gcnt0_q;
    assign bus.grant_cnt1 = gcnt1_q;
endmodule

// File: tb/tb_hdmi_rd_arbiter.sv
// Bench for hdmi_rd_arbiter: vector table plus hand sequences, with an ack-ordered
// scoreboard and a simple downstream read-engine model driving cmd_busy.
module tb_hdmi_rd_arbiter;
    logic clk_vga;
    logic rst;

    hdmi_rd_arbiter_if #(.CNT_W(16)) bus ();

    hdmi_rd_arbiter #(.STARVE_LIMIT(4), .CNT_W(16)) dut (
        .clk_vga (clk_vga),
        .rst     (rst),
        .bus     (bus)
    );

    initial clk_vga = 1'b0;
    always #5 clk_vga = ~clk_vga;

    typedef struct {
        logic [1:0]  kick;
        logic [31:0] a0, n0, b0, a1, n1, b1;
        logic        exp_port;
        logic [31:0] exp_addr, exp_num;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] addr, num;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   ack_seen = 0;
    int   done_seen = 0;
    int   exp_cnt0 = 0;
    int   exp_cnt1 = 0;

    logic model_busy;
    logic force_busy;
    logic model_hold;
    int   model_cnt;
    int   busy_len;

    assign bus.cmd_busy = model_busy | force_busy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Downstream engine: accepts cmd_kick by raising busy, drops it busy_len cycles later
    initial begin
        model_busy = 1'b0;
        model_cnt  = 0;
        forever begin
            @(posedge clk_vga);
            #1;
            if (model_busy) begin
                if (model_cnt <= 1) model_busy = 1'b0;
                else model_cnt--;
            end else if (bus.cmd_kick && !force_busy && !model_hold) begin
                model_busy = 1'b1;
                model_cnt  = busy_len;
            end
        end
    end

    // Scoreboard: each accepted command is matched against the oldest expectation
    always @(negedge clk_vga) begin
        if (bus.req_done != 2'b00) begin
            done_seen++;
            chk("done_onehot", 64'($onehot(bus.req_done)), 64'd1);
        end
        if (bus.req_ack != 2'b00) begin
            exp_t e;
            ack_seen++;
            if (sb.size() == 0) begin
                chk("ack_unexpected", 64'(bus.req_ack), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_port", 64'(bus.req_ack), e.port ? 64'd2 : 64'd1);
                if (e.num != 32'd0) begin
                    chk("cmd_addr", 64'(bus.cmd_addr), 64'(e.addr));
                    chk("cmd_num", 64'(bus.cmd_num), 64'(e.num));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

    task automatic start_req(input vec_t v);
        exp_t e;
        bus.req_addr0  = v.a0;  bus.req_num0 = v.n0;  bus.base_addr0 = v.b0;
        bus.req_addr1  = v.a1;  bus.req_num1 = v.n1;  bus.base_addr1 = v.b1;
        bus.req_kick   = v.kick;
        e.port = v.exp_port; e.addr = v.exp_addr; e.num = v.exp_num;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input logic port);
        int n = 0;
        while (!bus.req_ack[port] && n < 40) begin
            @(negedge clk_vga);
            n++;
        end
        if (!bus.req_ack[port]) chk("ack_timeout", 64'd0, 64'd1);
        else                    chk("ack_on_busy", 64'(bus.cmd_busy), 64'd1);
    endtask

    task automatic wait_done(input logic port);
        int n = 0;
        while (!bus.req_done[port] && n < 40) begin
            @(negedge clk_vga);
            n++;
        end
        if (!bus.req_done[port]) chk("done_timeout", 64'd0, 64'd1);
        else                     chk("done_on_idle_bus", 64'(bus.cmd_busy), 64'd0);
    endtask

    task automatic count_grant(input logic port);
        if (port) exp_cnt1++;
        else      exp_cnt0++;
    endtask

    task automatic run_vec(input vec_t v);
        start_req(v);
        @(negedge clk_vga);
        if (v.exp_num == 32'd0) begin
            chk("zero_ack", 64'(bus.req_ack), v.exp_port ? 64'd2 : 64'd1);
            chk("zero_done", 64'(bus.req_done), v.exp_port ? 64'd2 : 64'd1);
            chk("zero_no_kick", 64'(bus.cmd_kick), 64'd0);
            bus.req_kick = 2'b00;
        end else begin
            chk("kick_latency", 64'(bus.cmd_kick), 64'd1);
            wait_ack(v.exp_port);
            bus.req_kick = 2'b00;
            wait_done(v.exp_port);
        end
        count_grant(v.exp_port);
        @(negedge clk_vga);
        chk("grant_cnt0", 64'(bus.grant_cnt0), 64'(exp_cnt0));
        chk("grant_cnt1", 64'(bus.grant_cnt1), 64'(exp_cnt1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk_vga);
        rst = 1'b0;
        exp_cnt0 = 0;
        exp_cnt1 = 0;
    endtask

    vec_t vt[6];
    vec_t hv;

    initial begin
        int acks0, dones0;
        logic exp_seq[10];

        rst = 1'b1; force_busy = 1'b0; model_hold = 1'b0; busy_len = 3;
        bus.req_kick = 2'b00;
        bus.req_addr0 = '0; bus.req_addr1 = '0; bus.req_num0 = '0; bus.req_num1 = '0;
        bus.base_addr0 = '0; bus.base_addr1 = '0;

        //          kick   a0          n0     b0             a1        n1     b1             port  addr           num
        vt[0] = '{2'b01, 32'h400,    32'd64, 32'h1000_0000, 32'h0,    32'd0, 32'h0,         1'b0, 32'h1000_0400, 32'd64};
        vt[1] = '{2'b01, 32'h200,    32'd5,  32'hFFFF_FF00, 32'h0,    32'd0, 32'h0,         1'b0, 32'h0000_0100, 32'd5};
        vt[2] = '{2'b10, 32'h0,      32'd0,  32'h0,         32'h80,   32'd12, 32'h2000_0000, 1'b1, 32'h2000_0080, 32'd12};
        vt[3] = '{2'b10, 32'h0,      32'd0,  32'h0,         32'h44,   32'd0, 32'h2000_0000, 1'b1, 32'h2000_0044, 32'd0};
        vt[4] = '{2'b11, 32'h10,     32'd7,  32'h3000_0000, 32'h8,    32'd3, 32'h2000_0000, 1'b0, 32'h3000_0010, 32'd7};
        vt[5] = '{2'b01, 32'h20,     32'd0,  32'h3000_0000, 32'h0,    32'd0, 32'h0,         1'b0, 32'h3000_0020, 32'd0};

        repeat (3) @(negedge clk_vga);
        chk("rst_cmd_kick", 64'(bus.cmd_kick), 64'd0);
        chk("rst_cmd_addr", 64'(bus.cmd_addr), 64'd0);
        chk("rst_cmd_num",  64'(bus.cmd_num),  64'd0);
        chk("rst_req_ack",  64'(bus.req_ack),  64'd0);
        chk("rst_req_done", 64'(bus.req_done), 64'd0);
        chk("rst_gcnt0",    64'(bus.grant_cnt0), 64'd0);
        chk("rst_gcnt1",    64'(bus.grant_cnt1), 64'd0);
        rst = 1'b0;
        @(negedge clk_vga);

        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        // Requester withdraws while the command is still being offered
        model_hold = 1'b1;
        hv = '{2'b01, 32'h40, 32'd9, 32'h100, 32'h0, 32'd0, 32'h0, 1'b0, 32'h140, 32'd9};
        start_req(hv);
        @(negedge clk_vga);
        chk("issue_kick", 64'(bus.cmd_kick), 64'd1);
        bus.req_kick = 2'b00;
        repeat (2) @(negedge clk_vga);
        chk("issue_hold_kick", 64'(bus.cmd_kick), 64'd1);
        chk("issue_hold_addr", 64'(bus.cmd_addr), 64'h140);
        model_hold = 1'b0;
        wait_ack(1'b0);
        wait_done(1'b0);
        count_grant(1'b0);

        // Downstream busy when the request arrives
        force_busy = 1'b1;
        @(negedge clk_vga);
        acks0 = ack_seen;
        hv = '{2'b10, 32'h0, 32'd0, 32'h0, 32'h0, 32'd4, 32'h5000_0000, 1'b1, 32'h5000_0000, 32'd4};
        start_req(hv);
        repeat (3) @(negedge clk_vga);
        chk("busy_no_kick", 64'(bus.cmd_kick), 64'd0);
        chk("busy_no_ack", 64'(ack_seen), 64'(acks0));
        force_busy = 1'b0;
        @(negedge clk_vga);
        chk("grant_after_busy", 64'(bus.cmd_kick), 64'd1);
        wait_ack(1'b1);
        bus.req_kick = 2'b00;
        wait_done(1'b1);

        // Reset while waiting for the read to finish
        hv = '{2'b01, 32'h8, 32'd2, 32'h9000_0000, 32'h0, 32'd0, 32'h0, 1'b0, 32'h9000_0008, 32'd2};
        start_req(hv);
        wait_ack(1'b0);
        bus.req_kick = 2'b00;
        force_busy = 1'b1;
        @(negedge clk_vga);
        dones0 = done_seen;
        acks0  = ack_seen;
        rst = 1'b1;
        hv = '{2'b01, 32'hC, 32'd3, 32'hA000_0000, 32'h0, 32'd0, 32'h0, 1'b0, 32'hA000_000C, 32'd3};
        start_req(hv);
        repeat (2) @(negedge clk_vga);
        chk("rst_mid_kick", 64'(bus.cmd_kick), 64'd0);
        rst = 1'b0;
        exp_cnt0 = 0; exp_cnt1 = 0;
        repeat (4) @(negedge clk_vga);
        chk("rst_mid_no_done", 64'(done_seen), 64'(dones0));
        chk("rst_mid_no_ack", 64'(ack_seen), 64'(acks0));
        chk("rst_mid_no_grant", 64'(bus.grant_cnt0), 64'd0);
        chk("rst_mid_idle", 64'(bus.cmd_kick), 64'd0);
        force_busy = 1'b0;
        @(negedge clk_vga);
        chk("rst_mid_regrant", 64'(bus.cmd_kick), 64'd1);
        wait_ack(1'b0);
        bus.req_kick = 2'b00;
        wait_done(1'b0);

        // Both ports requesting continuously from a fresh reset
        @(negedge clk_vga);
        do_reset();
        busy_len = 2;
        exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        acks0 = ack_seen;
        bus.req_addr0 = 32'h0;  bus.req_num0 = 32'd16; bus.base_addr0 = 32'h6000_0000;
        bus.req_addr1 = 32'h4;  bus.req_num1 = 32'd8;  bus.base_addr1 = 32'h7000_0000;
        for (int i = 0; i < 10; i++) begin
            exp_t e;
            e.port = exp_seq[i];
            e.addr = exp_seq[i] ? 32'h7000_0004 : 32'h6000_0000;
            e.num  = exp_seq[i] ? 32'd8 : 32'd16;
            sb.push_back(e);
        end
        bus.req_kick = 2'b11;
        for (int n = 0; n < 300 && ack_seen < acks0 + 10; n++) @(negedge clk_vga);
        bus.req_kick = 2'b00;
        chk("stream_acks", 64'(ack_seen - acks0), 64'd10);
        repeat (8) @(negedge clk_vga);
        chk("stream_gcnt0", 64'(bus.grant_cnt0), 64'd8);
        chk("stream_gcnt1", 64'(bus.grant_cnt1), 64'd2);
        chk("stream_idle", 64'(bus.cmd_kick), 64'd0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
